tl_vehicle_sensor: RTL and testbench

//  Closed-loop model of the two-street intersection driven by the traffic-light controller.
//  - Consumes light codes La/Lb and per-street car arrival strobes.
//  - Keeps a saturating car queue per street and drains it while that street is green.
//  - Drives the sensor outputs Ta/Tb (street occupied) back into the controller.
//  - Flags queue overflow and unsafe light combinations for the bench.

---
 rtl/tl_vehicle_sensor_pkg.sv | 20 ++
 rtl/tl_lane_queue.sv | 75 +++++++
 rtl/tl_vehicle_sensor.sv | 70 +++++++
 tb/tb_tl_vehicle_sensor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tl_vehicle_sensor_pkg.sv
// Shared light encoding and helpers for the intersection model.
// Both the controller and the sensor model import this package.
package tl_vehicle_sensor_pkg;

    typedef enum logic [1:0] {
        TL_GREEN  = 2'b00,
        TL_YELLOW = 2'b01,
        TL_RED    = 2'b10
    } tl_light_e;

    // Code 2'b11 is not a legal light and behaves as RED.
    function automatic logic tl_is_red(input logic [1:0] light);
        return light[1];
    endfunction

    function automatic logic tl_is_green(input logic [1:0] light);
        return light == TL_GREEN;
    endfunction

endpackage

// File: rtl/tl_lane_queue.sv
// One street of the intersection: a saturating car queue that drains
// while the street is green, with a minimum gap between departures.
module tl_lane_queue
    import tl_vehicle_sensor_pkg::*;
#(
    parameter int QW         = 4,
    parameter int DEPART_GAP = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          arr_i,
    input  logic [1:0]    light_i,
    output logic [QW-1:0] cnt_o,
    output logic          served_o,
    output logic          ovf_o
);

    localparam int            GW       = $clog2(DEPART_GAP) + 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(DEPART_GAP - 1);
    localparam logic [QW-1:0] CNT_MAX  = '1;

    logic [QW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          served_q;
    logic          ovf_q, ovf_d;
    logic          green;
    logic          dep;

    assign green = tl_is_green(light_i);
    assign dep   = green && (cnt_q != '0) && (gap_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        gap_d = gap_q;

        // Arrival and departure in the same cycle cancel; never an overflow.
        if (arr_i && !dep) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!arr_i && dep) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (!green) begin
            gap_d = '0;
        end else if (dep) begin
            gap_d = GAP_LOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            gap_q    <= '0;
            served_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            served_q <= dep;
            ovf_q    <= ovf_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign served_o = served_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/tl_vehicle_sensor.sv
// Closed-loop intersection model: two lane queues, occupancy sensors
// fed back to the controller, and a sticky unsafe-lights flag.
module tl_vehicle_sensor
    import tl_vehicle_sensor_pkg::*;
#(
    parameter int QW         = 4,
    parameter int DEPART_GAP = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          arr_a,
    input  logic          arr_b,
    input  logic [1:0]    La,
    input  logic [1:0]    Lb,
    output logic          Ta,
    output logic          Tb,
    output logic [QW-1:0] cnt_a,
    output logic [QW-1:0] cnt_b,
    output logic          served_a,
    output logic          served_b,
    output logic          ovf_a,
    output logic          ovf_b,
    output logic          conflict
);

    logic conflict_q;
    logic both_open;

    tl_lane_queue #(
        .QW         (QW),
        .DEPART_GAP (DEPART_GAP)
    ) u_lane_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .arr_i    (arr_a),
        .light_i  (La),
        .cnt_o    (cnt_a),
        .served_o (served_a),
        .ovf_o    (ovf_a)
    );

    tl_lane_queue #(
        .QW         (QW),
        .DEPART_GAP (DEPART_GAP)
    ) u_lane_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .arr_i    (arr_b),
        .light_i  (Lb),
        .cnt_o    (cnt_b),
        .served_o (served_b),
        .ovf_o    (ovf_b)
    );

    // Observation only: the lanes keep draining even when this is set.
    assign both_open = !tl_is_red(La) && !tl_is_red(Lb);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_q <= 1'b0;
        end else if (both_open) begin
            conflict_q <= 1'b1;
        end
    end

    assign conflict = conflict_q;
    assign Ta       = |cnt_a;
    assign Tb       = |cnt_b;

endmodule

// File: tb/tb_tl_vehicle_sensor.sv
// Scoreboard bench for tl_vehicle_sensor: a gap-2 and a gap-1 instance
// share stimulus and are compared each cycle against a behavioural model.
module tb_tl_vehicle_sensor;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       arr_a = 1'b0, arr_b = 1'b0;
    logic [1:0] La = R, Lb = R;

    logic       ta0, tb0, sa0, sb0, oa0, ob0, cf0;
    logic [3:0] ca0, cb0;
    logic       ta1, tb1, sa1, sb1, oa1, ob1, cf1;
    logic [3:0] ca1, cb1;

    always #5 clk = ~clk;

    tl_vehicle_sensor #(.QW(4), .DEPART_GAP(2)) dut (
        .clk(clk), .reset_n(reset_n), .arr_a(arr_a), .arr_b(arr_b),
        .La(La), .Lb(Lb), .Ta(ta0), .Tb(tb0), .cnt_a(ca0), .cnt_b(cb0),
        .served_a(sa0), .served_b(sb0), .ovf_a(oa0), .ovf_b(ob0), .conflict(cf0)
    );

    tl_vehicle_sensor #(.QW(4), .DEPART_GAP(1)) dut_g1 (
        .clk(clk), .reset_n(reset_n), .arr_a(arr_a), .arr_b(arr_b),
        .La(La), .Lb(Lb), .Ta(ta1), .Tb(tb1), .cnt_a(ca1), .cnt_b(cb1),
        .served_a(sa1), .served_b(sb1), .ovf_a(oa1), .ovf_b(ob1), .conflict(cf1)
    );

    typedef struct {
        int cnt_a, cnt_b, sa, sb, oa, ob, cf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int m_cnt [2][2];
    int m_gap [2][2];
    int m_ovf [2][2];
    int m_srv [2][2];
    int m_conf[2];
    int gap_of[2] = '{2, 1};

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_conf[i] = 0;
            for (int l = 0; l < 2; l++) begin
                m_cnt[i][l] = 0; m_gap[i][l] = 0; m_ovf[i][l] = 0; m_srv[i][l] = 0;
            end
        end
    endtask

    task automatic model_step();
        logic [1:0] lt [2];
        logic       ar [2];
        bit         green, dep;
        lt[0] = La; lt[1] = Lb; ar[0] = arr_a; ar[1] = arr_b;
        for (int i = 0; i < 2; i++) begin
            for (int l = 0; l < 2; l++) begin
                green = (lt[l] == G);
                dep   = green && m_cnt[i][l] != 0 && m_gap[i][l] == 0;
                if (ar[l] && !dep) begin
                    if (m_cnt[i][l] == 15) m_ovf[i][l] = 1;
                    else                   m_cnt[i][l]++;
                end else if (!ar[l] && dep) begin
                    m_cnt[i][l]--;
                end
                if (!green)               m_gap[i][l] = 0;
                else if (dep)             m_gap[i][l] = gap_of[i] - 1;
                else if (m_gap[i][l] > 0) m_gap[i][l]--;
                m_srv[i][l] = dep ? 1 : 0;
            end
            if (La != R && La != X && Lb != R && Lb != X) m_conf[i] = 1;
            sb_q.push_back('{m_cnt[i][0], m_cnt[i][1], m_srv[i][0], m_srv[i][1],
                             m_ovf[i][0], m_ovf[i][1], m_conf[i]});
        end
    endtask

    task automatic compare_inst(input string nm, input exp_t e,
                                input logic [3:0] ca, input logic [3:0] cb,
                                input logic ta, input logic tb, input logic sa,
                                input logic sb, input logic oa, input logic ob,
                                input logic cf);
        check_eq({nm, ".cnt_a"}, int'(ca), e.cnt_a);
        check_eq({nm, ".cnt_b"}, int'(cb), e.cnt_b);
        check_eq({nm, ".Ta"}, int'(ta), (e.cnt_a != 0) ? 1 : 0);
        check_eq({nm, ".Tb"}, int'(tb), (e.cnt_b != 0) ? 1 : 0);
        check_eq({nm, ".served_a"}, int'(sa), e.sa);
        check_eq({nm, ".served_b"}, int'(sb), e.sb);
        check_eq({nm, ".ovf_a"}, int'(oa), e.oa);
        check_eq({nm, ".ovf_b"}, int'(ob), e.ob);
        check_eq({nm, ".conflict"}, int'(cf), e.cf);
    endtask

    // Inputs change 1 ns after an edge; outputs are sampled 1 ns after the next edge.
    task automatic cycle(input logic aa, input logic ab, input logic [1:0] la, input logic [1:0] lb);
        exp_t e0, e1;
        arr_a = aa; arr_b = ab; La = la; Lb = lb;
        model_step();
        @(posedge clk);
        #1;
        check_eq("sb_depth", sb_q.size(), 2);
        if (sb_q.size() >= 2) begin
            e0 = sb_q.pop_front();
            e1 = sb_q.pop_front();
            compare_inst("g2", e0, ca0, cb0, ta0, tb0, sa0, sb0, oa0, ob0, cf0);
            compare_inst("g1", e1, ca1, cb1, ta1, tb1, sa1, sb1, oa1, ob1, cf1);
        end
        sb_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".cnt"},  int'({ca0, cb0, ca1, cb1}), 0);
        check_eq({tag, ".T"},    int'({ta0, tb0, ta1, tb1}), 0);
        check_eq({tag, ".srv"},  int'({sa0, sb0, sa1, sb1}), 0);
        check_eq({tag, ".ovf"},  int'({oa0, ob0, oa1, ob1}), 0);
        check_eq({tag, ".conf"}, int'({cf0, cf1}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] pla, plb;
        int         ph;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Arrivals on a red street accumulate with no departures.
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b1, 1'b0, R, R);
            check_eq("t1_cnt_a", int'(ca0), k);
            check_eq("t1_Ta", int'(ta0), 1);
        end

        // Green drain: gap-2 pulses on edges 1,3,5; gap-1 on edges 1,2,3.
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 1'b0, G, R);
            if (k == 1 || k == 3 || k == 5) check_eq("t2_served_g2", int'(sa0), 1);
            if (k <= 3) check_eq("t2_served_g1", int'(sa1), 1);
        end
        check_eq("t2_cnt_a_end", int'(ca0), 0);
        check_eq("t2_Ta_end", int'(ta0), 0);

        // Fill B past capacity on red, then drain on green; overflow stays sticky.
        for (int k = 0; k < 18; k++) cycle(1'b0, 1'b1, R, R);
        check_eq("t3_cnt_b_sat", int'(cb0), 15);
        check_eq("t3_ovf_b", int'(ob0), 1);
        for (int k = 0; k < 34; k++) cycle(1'b0, 1'b0, R, G);
        check_eq("t3_cnt_b_drained", int'(cb0), 0);
        check_eq("t3_ovf_b_sticky", int'(ob0), 1);

        // Arrivals held high during green: departure edges hold, gap edges add.
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, R, R);
        check_eq("t4_cnt_a_pre", int'(ca0), 5);
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, G, R);

        // 2'b11 counts as red; yellow against green is a conflict.
        cycle(1'b0, 1'b0, G, X);
        cycle(1'b0, 1'b0, G, X);
        check_eq("t5_no_conflict_11", int'(cf0), 0);
        cycle(1'b0, 1'b0, G, Y);
        check_eq("t5_conflict_set", int'(cf0), 1);
        cycle(1'b0, 1'b0, R, R);
        cycle(1'b0, 1'b0, R, R);
        check_eq("t5_conflict_held", int'(cf0), 1);

        // Asynchronous reset in the middle of a drain, between clock edges.
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, R, R);
        cycle(1'b0, 1'b0, G, R);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Closed loop: a safe alternating light sequence with random arrivals.
        for (int k = 0; k < 200; k++) begin
            ph = k % 20;
            if (ph < 8)       begin pla = G; plb = R; end
            else if (ph < 10) begin pla = Y; plb = R; end
            else if (ph < 18) begin pla = R; plb = G; end
            else              begin pla = R; plb = Y; end
            if (k < 80) cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), pla, plb);
            else        cycle(1'b0, 1'b0, pla, plb);
        end
        check_eq("loop_cnt_a_drained", int'(ca0), 0);
        check_eq("loop_cnt_b_drained", int'(cb0), 0);
        check_eq("loop_no_conflict", int'(cf0), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
